massbus_mux: RTL and testbench



---
 rtl/massbus_pkg.sv | 13 +
 rtl/massbus_rrarb.sv | 28 ++
 rtl/massbus_mux.sv | 143 ++++++++++++++
 tb/tb_massbus_mux.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/massbus_pkg.sv
// Shared types and constants for the Massbus drive-side multiplexer.
package massbus_pkg;
    localparam int MB_DWIDTH   = 36;
    localparam int MB_MAXUNITS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mbState_t;

    typedef logic [$clog2(MB_MAXUNITS)-1:0] mbUnit_t;
endpackage

// File: rtl/massbus_rrarb.sv
// Combinational round-robin priority encoder: first set request at or above ptr, wrapping.
import massbus_pkg::*;

module massbus_rrarb #(
    parameter int NUNITS = MB_MAXUNITS,
    parameter int IW     = (NUNITS > 1) ? $clog2(NUNITS) : 1
) (
    input  logic [NUNITS-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic              any,
    output logic [IW-1:0]     idx
);

    function automatic int slotOf(input int base, input int k);
        slotOf = (base + k >= NUNITS) ? (base + k - NUNITS) : (base + k);
    endfunction

    // Scan from the farthest slot back to ptr so the nearest request is the last one written.
    always_comb begin
        any = 1'b0;
        idx = {IW{1'b0}};
        for (int k = NUNITS - 1; k >= 0; k--) begin
            any = any | req[slotOf(int'(ptr), k)];
            idx = req[slotOf(int'(ptr), k)] ? IW'(slotOf(int'(ptr), k)) : idx;
        end
    end

endmodule

// File: rtl/massbus_mux.sv
// Massbus drive-side multiplexer: round-robin drive arbitration onto one master handshake.
// Optional request timeout is built when MASSBUS_MUX_TIMEOUT_EN is defined.
import massbus_pkg::*;

module massbus_mux #(
    parameter int NUNITS  = MB_MAXUNITS,
    parameter int DWIDTH  = MB_DWIDTH,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mbINIT,
    output logic                     mbREQO,
    input  logic                     mbACKI,
    output logic [DWIDTH-1:0]        mbDATAO,
    input  logic [DWIDTH-1:0]        mbDATAI,
    output logic [NUNITS-1:0]        mbATA,
    output logic                     mbATASUM,
    output logic [NUNITS-1:0]        mbDVA,
    output logic                     mbTMO,
    input  logic [NUNITS-1:0]        drvREQ,
    input  logic [NUNITS*DWIDTH-1:0] drvDATAO,
    output logic [NUNITS-1:0]        drvACK,
    output logic [NUNITS-1:0]        drvABORT,
    output logic [DWIDTH-1:0]        drvDATAI,
    input  logic [NUNITS-1:0]        drvATA,
    input  logic [NUNITS-1:0]        drvDVA
);

    localparam int IW = (NUNITS > 1) ? $clog2(NUNITS) : 1;
    localparam logic [NUNITS-1:0] UNIT_ONE = {{(NUNITS-1){1'b0}}, 1'b1};

    mbState_t      state_r;
    logic [IW-1:0] ptr_r;
    logic [IW-1:0] grant_r;
    logic          arbAny_s;
    logic [IW-1:0] arbIdx_s;
    logic          expire_s;

    massbus_rrarb #(
        .NUNITS (NUNITS),
        .IW     (IW)
    ) u_arb (
        .req (drvREQ),
        .ptr (ptr_r),
        .any (arbAny_s),
        .idx (arbIdx_s)
    );

    // Handshake FSM; the DONE guard cycle gives the drive time to drop its request.
    always_ff @(posedge clk) begin
        if (rst || mbINIT) begin
            state_r  <= IDLE;
            ptr_r    <= {IW{1'b0}};
            grant_r  <= {IW{1'b0}};
            mbREQO   <= 1'b0;
            mbDATAO  <= {DWIDTH{1'b0}};
            drvDATAI <= {DWIDTH{1'b0}};
            drvACK   <= {NUNITS{1'b0}};
        end else begin
            drvACK <= {NUNITS{1'b0}};
            case (state_r)
                IDLE: begin
                    if (arbAny_s) begin
                        grant_r <= arbIdx_s;
                        mbDATAO <= drvDATAO[arbIdx_s*DWIDTH +: DWIDTH];
                        mbREQO  <= 1'b1;
                        state_r <= REQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (mbACKI) begin
                        drvDATAI <= mbDATAI;
                        drvACK   <= UNIT_ONE << grant_r;
                        mbREQO   <= 1'b0;
                        state_r  <= DONE;
                    end else if (expire_s) begin
                        mbREQO  <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        state_r <= REQ;
                    end
                end
                DONE: begin
                    ptr_r   <= (grant_r == IW'(NUNITS - 1)) ? {IW{1'b0}} : grant_r + 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    mbREQO  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Attention / available status is a plain one-cycle register stage.
    always_ff @(posedge clk) begin
        if (rst || mbINIT) begin
            mbATA    <= {NUNITS{1'b0}};
            mbATASUM <= 1'b0;
            mbDVA    <= {NUNITS{1'b0}};
        end else begin
            mbATA    <= drvATA;
            mbATASUM <= |drvATA;
            mbDVA    <= drvDVA;
        end
    end

`ifdef MASSBUS_MUX_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] tmoCnt_r;
    logic          abortEvt_s;

    assign expire_s   = (tmoCnt_r == CW'(TIMEOUT - 1));
    // A same-cycle acknowledge takes priority over expiry.
    assign abortEvt_s = (state_r == REQ) && !mbACKI && expire_s;

    // Saturating REQ-cycle counter, abort pulse and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst || mbINIT) begin
            tmoCnt_r <= {CW{1'b0}};
            drvABORT <= {NUNITS{1'b0}};
            mbTMO    <= 1'b0;
        end else begin
            tmoCnt_r <= (state_r != REQ) ? {CW{1'b0}} :
                        (&tmoCnt_r)      ? tmoCnt_r   : tmoCnt_r + 1'b1;
            drvABORT <= abortEvt_s ? (UNIT_ONE << grant_r) : {NUNITS{1'b0}};
            mbTMO    <= mbTMO | abortEvt_s;
        end
    end
`else
    logic unusedTimeout_s;

    assign expire_s        = 1'b0;
    assign mbTMO           = 1'b0;
    assign drvABORT        = {NUNITS{1'b0}};
    assign unusedTimeout_s = (TIMEOUT > 1);
`endif

endmodule

// File: tb/tb_massbus_mux.sv
// Directed self-checking bench for massbus_mux (8 units, 36-bit words, TIMEOUT=16).
module tb_massbus_mux;
    localparam int NU = 8;
    localparam int DW = 36;

    logic           clk = 1'b0;
    logic           rst, mbINIT, mbACKI;
    logic           mbREQO, mbATASUM, mbTMO;
    logic [DW-1:0]  mbDATAO, mbDATAI, drvDATAI;
    logic [NU-1:0]  mbATA, mbDVA, drvREQ, drvACK, drvABORT, drvATA, drvDVA;
    logic [NU*DW-1:0] drvDATAO;

    int errCnt = 0;
    int chkCnt = 0;
    int n;
    int gap;
    logic [7:0] rrExp [4] = '{8'h01, 8'h04, 8'h01, 8'h04};

    massbus_mux #(.NUNITS(NU), .DWIDTH(DW), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .mbINIT(mbINIT),
        .mbREQO(mbREQO), .mbACKI(mbACKI), .mbDATAO(mbDATAO), .mbDATAI(mbDATAI),
        .mbATA(mbATA), .mbATASUM(mbATASUM), .mbDVA(mbDVA), .mbTMO(mbTMO),
        .drvREQ(drvREQ), .drvDATAO(drvDATAO), .drvACK(drvACK), .drvABORT(drvABORT),
        .drvDATAI(drvDATAI), .drvATA(drvATA), .drvDVA(drvDVA)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mbINIT = 1'b0; mbACKI = 1'b0; mbDATAI = '0;
        drvREQ = '0; drvDATAO = '0; drvATA = '0; drvDVA = '0;
        cycle(); cycle();
        rst = 1'b0;
        check("rst_req",   {63'd0, mbREQO}, 64'd0);
        check("rst_dato",  {28'd0, mbDATAO}, 64'd0);
        check("rst_dati",  {28'd0, drvDATAI}, 64'd0);
        check("rst_ack",   {56'd0, drvACK}, 64'd0);
        check("rst_abort", {56'd0, drvABORT}, 64'd0);
        check("rst_tmo",   {63'd0, mbTMO}, 64'd0);
        check("rst_vec",   {47'd0, mbATA, mbDVA, mbATASUM}, 64'd0);

        // Single request from drive 3
        drvDATAO[3*DW +: DW] = 36'o123456701234;
        drvREQ = 8'h08;
        cycle();
        check("sr_req1",  {63'd0, mbREQO}, 64'd1);
        check("sr_dato1", {28'd0, mbDATAO}, {28'd0, 36'o123456701234});
        drvDATAO[3*DW +: DW] = 36'o555555555555;
        cycle();
        check("sr_dato2", {28'd0, mbDATAO}, {28'd0, 36'o123456701234});
        mbACKI = 1'b1; mbDATAI = 36'o777000111222;
        cycle();
        check("sr_ack",   {56'd0, drvACK}, 64'h08);
        check("sr_dati",  {28'd0, drvDATAI}, {28'd0, 36'o777000111222});
        check("sr_reqlo", {63'd0, mbREQO}, 64'd0);
        mbACKI = 1'b0; drvREQ = '0;
        cycle();
        check("sr_ackw",  {56'd0, drvACK}, 64'd0);

        // Acknowledge outside REQ is ignored
        mbACKI = 1'b1; mbDATAI = 36'o1;
        cycle();
        check("ign_ack",  {56'd0, drvACK}, 64'd0);
        check("ign_dati", {28'd0, drvDATAI}, {28'd0, 36'o777000111222});
        mbACKI = 1'b0;

        // Round-robin with units 0 and 2 held from reset
        drvREQ = 8'h05; rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            gap = 0;
            while (!mbREQO && gap < 10) begin
                cycle();
                gap++;
            end
            check("rr_req", {63'd0, mbREQO}, 64'd1);
            if (i > 0) check("rr_gap", 64'(gap), 64'd2);
            mbACKI = 1'b1;
            cycle();
            mbACKI = 1'b0;
            check("rr_ack",   {56'd0, drvACK}, {56'd0, rrExp[i]});
            check("rr_reqlo", {63'd0, mbREQO}, 64'd0);
        end
        drvREQ = '0;
        cycle(); cycle();

        // Timeout with no acknowledge, drive 5
        drvREQ = 8'h20;
        cycle();
        n = 0;
        for (int k = 0; k < 40 && mbREQO; k++) begin
            n++;
            cycle();
        end
`ifdef MASSBUS_MUX_TIMEOUT_EN
        check("to_len",   64'(n), 64'd16);
        check("to_abort", {56'd0, drvABORT}, 64'h20);
        check("to_tmo",   {63'd0, mbTMO}, 64'd1);
        check("to_noack", {56'd0, drvACK}, 64'd0);
        drvREQ = '0;
        cycle();
        check("to_abw",   {56'd0, drvABORT}, 64'd0);
        cycle(); cycle();
        check("to_stick", {63'd0, mbTMO}, 64'd1);
`else
        check("to_len",   64'(n), 64'd40);
        check("to_tmo",   {63'd0, mbTMO}, 64'd0);
        check("to_abort", {56'd0, drvABORT}, 64'd0);
        mbACKI = 1'b1;
        cycle();
        mbACKI = 1'b0;
        check("to_ack",   {56'd0, drvACK}, 64'h20);
        drvREQ = '0;
        cycle();
`endif
        mbINIT = 1'b1;
        cycle();
        mbINIT = 1'b0;
        check("to_init",  {63'd0, mbTMO}, 64'd0);

        // Acknowledge in the 16th REQ cycle beats expiry
        drvREQ = 8'h02;
        cycle();
        for (int k = 1; k < 16; k++) cycle();
        check("sim_req",   {63'd0, mbREQO}, 64'd1);
        mbACKI = 1'b1;
        cycle();
        mbACKI = 1'b0;
        check("sim_ack",   {56'd0, drvACK}, 64'h02);
        check("sim_abort", {56'd0, drvABORT}, 64'd0);
        check("sim_tmo",   {63'd0, mbTMO}, 64'd0);
        drvREQ = '0;
        cycle();

        // Init mid-transfer: ptr is 2, so unit 3 wins first
        drvDATAO[0 +: DW] = 36'o000000000055;
        drvREQ = 8'h09;
        cycle();
        check("ini_g3",    {28'd0, mbDATAO}, {28'd0, 36'o555555555555});
        mbINIT = 1'b1;
        cycle();
        mbINIT = 1'b0;
        check("ini_reqlo", {63'd0, mbREQO}, 64'd0);
        check("ini_ack",   {56'd0, drvACK}, 64'd0);
        check("ini_abort", {56'd0, drvABORT}, 64'd0);
        check("ini_tmo",   {63'd0, mbTMO}, 64'd0);
        cycle();
        check("ini_req",   {63'd0, mbREQO}, 64'd1);
        check("ini_g0",    {28'd0, mbDATAO}, {28'd0, 36'o000000000055});
        mbACKI = 1'b1;
        cycle();
        mbACKI = 1'b0;
        check("ini_ack0",  {56'd0, drvACK}, 64'h01);
        drvREQ = '0;
        cycle();

        // Attention / available vectors
        drvATA = 8'h81; drvDVA = 8'hFF;
        check("vec_lag",   {56'd0, mbATA}, 64'd0);
        cycle();
        check("vec_ata",   {56'd0, mbATA}, 64'h81);
        check("vec_sum1",  {63'd0, mbATASUM}, 64'd1);
        check("vec_dva",   {56'd0, mbDVA}, 64'hFF);
        drvATA = 8'h00;
        cycle();
        check("vec_sum0",  {63'd0, mbATASUM}, 64'd0);
        check("vec_ata0",  {56'd0, mbATA}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end
endmodule
